// File: rtl/instr_fetch_pkg.sv
// ----------------------------------------------------------------------------
// instr_fetch_pkg
// Shared definitions for the instruction fetch unit:
//   - default address/data widths and buffer depth
//   - position of the opcode field inside an instruction word
//   - the HALT opcode that ends a program early
//   - the fetch controller state enumeration
// ----------------------------------------------------------------------------
package instr_fetch_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 2;

  // Opcode field sits in bits [12:9] of every instruction word.
  localparam int OP_MSB = 12;
  localparam int OP_LSB = 9;

  localparam logic [3:0] HALT_OP = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic is_halt(input logic [3:0] opcode);
    return opcode == HALT_OP;
  endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo
// Small circular FIFO holding fetched instructions tagged with their address.
// Ports:
//   clk, reset    - clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata   - write request and entry; accepted when not full, or when
//                   a pop happens in the same cycle
//   pop           - remove head entry (ignored when empty)
//   rdata         - head entry (meaningful only when not empty)
//   full, empty   - occupancy flags
//   count         - number of stored entries
// ----------------------------------------------------------------------------
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 20
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] slots [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap at DEPTH so non-power-of-two depths work too.
  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign rdata = slots[head];

  // Storage needs no reset: the head is never looked at while empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      slots[tail] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        tail <= bump(tail);
      end
      if (do_pop) begin
        head <= bump(head);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch
// Fetches a program of prog_len words (0 means a full 2^ADDR_W) starting at
// start_addr from a synchronous RAM (one-cycle read latency), buffers the
// words in a small FIFO and hands them to a downstream controller with a
// valid/ready handshake. A word whose opcode is HALT ends the program early.
// Ports:
//   clk, reset              - clock, asynchronous active-low reset
//   start, start_addr,
//   prog_len                - program request, honoured only when idle
//   mem_addr, mem_rd_en     - RAM read request
//   mem_rdata               - RAM data, valid the cycle after mem_rd_en
//   ins, ins_pc, ins_valid,
//   ins_ready               - instruction stream to the controller
//   busy                    - unit is not idle
//   done                    - one-cycle pulse after the program is delivered
// ----------------------------------------------------------------------------
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] prog_len,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ins,
  output logic [ADDR_W-1:0] ins_pc,
  output logic              ins_valid,
  input  logic              ins_ready,
  output logic              busy,
  output logic              done
);

  localparam int ENTRY_W = DATA_W + ADDR_W;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  state_t state;
  state_t state_next;

  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W:0]    remaining;
  logic               inflight;
  logic [ADDR_W-1:0]  inflight_pc;

  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] wdata;
  logic [ENTRY_W-1:0] rdata;
  logic               full;
  logic               empty;
  logic [CNT_W-1:0]   count;

  logic               halt_hit;
  logic               room;
  logic               issue;
  logic [CNT_W:0]     occupancy;
  logic [CNT_W:0]     limit;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Every returning word goes into the buffer tagged with its address.
  assign push  = inflight;
  assign wdata = {mem_rdata, inflight_pc};
  assign pop   = !empty && ins_ready;

  assign halt_hit = inflight && is_halt(mem_rdata[OP_MSB:OP_LSB]);

  // Slots already buffered or promised to a read in flight must leave room
  // for a new read. A head leaving this cycle frees a slot, which is what
  // lets the unit sustain one instruction per cycle with a two-entry buffer.
  assign occupancy = {1'b0, count} + (CNT_W + 1)'(inflight);
  assign limit     = (CNT_W + 1)'(DEPTH) + (CNT_W + 1)'(pop);
  assign room      = full ? (pop && !inflight) : (occupancy < limit);

  // No read is issued in the cycle a HALT arrives, so nothing past the HALT
  // is ever requested or buffered.
  assign issue = (state == FETCH) && (remaining != '0) && room && !halt_hit;

  assign mem_rd_en = issue;
  assign mem_addr  = pc;

  // Outputs are forced to zero when the buffer is empty so stale entries
  // never show up on the instruction bus.
  assign ins_valid = !empty;
  assign ins       = empty ? '0 : rdata[ENTRY_W-1:ADDR_W];
  assign ins_pc    = empty ? '0 : rdata[ADDR_W-1:0];

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. DRAIN looks one cycle ahead so that done follows the
  // final transfer directly.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (halt_hit || remaining == '0) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!inflight && (empty || (count == CNT_W'(1) && pop))) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Program counter, words left to request and the read-in-flight tracker.
  // The inflight flag is cleared by reset, so data returning from a read
  // issued before reset is never buffered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= '0;
      remaining   <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= issue;
      if (state == IDLE && start) begin
        pc        <= start_addr;
        remaining <= (prog_len == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, prog_len};
      end else if (issue) begin
        pc          <= pc + ADDR_W'(1);
        remaining   <= remaining - (ADDR_W + 1)'(1);
        inflight_pc <= pc;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch
// Directed bench for instr_fetch with a synchronous RAM model. Each program
// run is recorded (issued addresses, transfers, done timing) and compared
// against hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  start_addr = '0;
  logic [3:0]  prog_len = '0;
  logic [3:0]  mem_addr;
  logic        mem_rd_en;
  logic [15:0] mem_rdata = '0;
  logic [15:0] ins;
  logic [3:0]  ins_pc;
  logic        ins_valid;
  logic        ins_ready = 1'b0;
  logic        busy;
  logic        done;

  logic [15:0] ram [16];

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] got_ins [$];
  logic [3:0]  got_pc [$];
  logic [3:0]  iss_addr [$];
  int first_issue_k;
  int first_valid_k;
  int last_xfer_k;
  int done_k;

  instr_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .prog_len   (prog_len),
    .mem_addr   (mem_addr),
    .mem_rd_en  (mem_rd_en),
    .mem_rdata  (mem_rdata),
    .ins        (ins),
    .ins_pc     (ins_pc),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse start from an idle cycle; returns at the first cycle of FETCH.
  // The request inputs are scrambled afterwards, which must have no effect.
  task automatic start_prog(input logic [3:0] addr, input logic [3:0] len);
    @(negedge clk);
    start      = 1'b1;
    start_addr = addr;
    prog_len   = len;
    @(negedge clk);
    start      = 1'b0;
    start_addr = ~addr;
    prog_len   = ~len;
  endtask

  // Record issues and transfers cycle by cycle until done or budget expires.
  task automatic collect(input string tag, input int budget);
    got_ins.delete();
    got_pc.delete();
    iss_addr.delete();
    first_issue_k = -1;
    first_valid_k = -1;
    last_xfer_k   = -1;
    done_k        = -1;
    for (int k = 0; k < budget; k++) begin
      if (mem_rd_en) begin
        iss_addr.push_back(mem_addr);
        if (first_issue_k < 0) first_issue_k = k;
      end
      if (ins_valid && first_valid_k < 0) first_valid_k = k;
      if (ins_valid && ins_ready) begin
        got_ins.push_back(ins);
        got_pc.push_back(ins_pc);
        last_xfer_k = k;
      end
      if (done) begin
        done_k = k;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_done_seen"}, 32'(done_k >= 0), 32'd1);
  endtask

  task automatic check_xfer(input string tag, input int j,
                            input logic [15:0] e_ins, input logic [3:0] e_pc);
    logic [15:0] o_ins;
    logic [3:0]  o_pc;
    o_ins = (j < got_ins.size()) ? got_ins[j] : 'x;
    o_pc  = (j < got_pc.size())  ? got_pc[j]  : 'x;
    check($sformatf("%s_ins%0d", tag, j), 32'(o_ins), 32'(e_ins));
    check($sformatf("%s_pc%0d", tag, j), 32'(o_pc), 32'(e_pc));
  endtask

  initial begin
    int n_iss;
    for (int i = 0; i < 16; i++) ram[i] = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
    check("rst_ins", 32'(ins), 32'd0);
    check("rst_ins_pc", 32'(ins_pc), 32'd0);
    check("rst_ins_valid", 32'(ins_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // Basic four-word program with latency and done timing
    $display("[TB] basic program");
    ram[0] = 16'h0011; ram[1] = 16'h0022; ram[2] = 16'h1048; ram[3] = 16'h0123;
    ins_ready = 1'b1;
    start_prog(4'd0, 4'd4);
    collect("basic", 40);
    check("basic_first_issue", 32'(first_issue_k), 32'd0);
    check("basic_first_valid", 32'(first_valid_k), 32'd2);
    check("basic_count", 32'(got_ins.size()), 32'd4);
    check_xfer("basic", 0, 16'h0011, 4'd0);
    check_xfer("basic", 1, 16'h0022, 4'd1);
    check_xfer("basic", 2, 16'h1048, 4'd2);
    check_xfer("basic", 3, 16'h0123, 4'd3);
    check("basic_done_timing", 32'(done_k), 32'(last_xfer_k + 1));
    @(negedge clk);
    check("basic_done_pulse", 32'(done), 32'd0);
    check("basic_busy_after", 32'(busy), 32'd0);

    // Address wrap 14,15,0
    $display("[TB] address wrap");
    ram[14] = 16'h0E0E; ram[15] = 16'h0F0F; ram[0] = 16'h0011;
    start_prog(4'd14, 4'd3);
    collect("wrap", 40);
    check("wrap_issues", 32'(iss_addr.size()), 32'd3);
    check("wrap_iss0", 32'((iss_addr.size() > 0) ? iss_addr[0] : 4'hx), 32'd14);
    check("wrap_iss1", 32'((iss_addr.size() > 1) ? iss_addr[1] : 4'hx), 32'd15);
    check("wrap_iss2", 32'((iss_addr.size() > 2) ? iss_addr[2] : 4'hx), 32'd0);
    check("wrap_count", 32'(got_ins.size()), 32'd3);
    check_xfer("wrap", 0, 16'h0E0E, 4'd14);
    check_xfer("wrap", 1, 16'h0F0F, 4'd15);
    check_xfer("wrap", 2, 16'h0011, 4'd0);

    // HALT at address 2 ends a six-word program after three words
    $display("[TB] halt");
    ram[0] = 16'h0011; ram[1] = 16'h0022; ram[2] = 16'h1E00;
    ram[3] = 16'h0333; ram[4] = 16'h0444; ram[5] = 16'h0555;
    start_prog(4'd0, 4'd6);
    collect("halt", 40);
    check("halt_count", 32'(got_ins.size()), 32'd3);
    check_xfer("halt", 0, 16'h0011, 4'd0);
    check_xfer("halt", 1, 16'h0022, 4'd1);
    check_xfer("halt", 2, 16'h1E00, 4'd2);

    // Back-pressure: ready low for five cycles, a stray start is ignored
    $display("[TB] back-pressure");
    ram[8] = 16'h0808; ram[9] = 16'h0909; ram[10] = 16'h0A0A; ram[11] = 16'h0B0B;
    ins_ready = 1'b0;
    start_prog(4'd8, 4'd4);
    n_iss = 0;
    for (int k = 0; k < 5; k++) begin
      if (mem_rd_en) n_iss++;
      start      = (k == 1);
      start_addr = 4'd0;
      prog_len   = 4'd1;
      @(negedge clk);
    end
    start = 1'b0;
    check("bp_issues", 32'(n_iss), 32'd2);
    check("bp_valid", 32'(ins_valid), 32'd1);
    check("bp_hold_ins", 32'(ins), 32'h0808);
    check("bp_hold_pc", 32'(ins_pc), 32'd8);
    ins_ready = 1'b1;
    collect("bp", 40);
    check("bp_count", 32'(got_ins.size()), 32'd4);
    check_xfer("bp", 0, 16'h0808, 4'd8);
    check_xfer("bp", 1, 16'h0909, 4'd9);
    check_xfer("bp", 2, 16'h0A0A, 4'd10);
    check_xfer("bp", 3, 16'h0B0B, 4'd11);

    // prog_len 0 means sixteen words, one per cycle
    $display("[TB] full sixteen-word program");
    for (int i = 0; i < 16; i++) ram[i] = 16'h0100 | 16'(i);
    start_prog(4'd5, 4'd0);
    collect("len16", 80);
    check("len16_count", 32'(got_ins.size()), 32'd16);
    for (int j = 0; j < 16; j++) begin
      check_xfer("len16", j, 16'h0100 | 16'((5 + j) % 16), 4'((5 + j) % 16));
    end
    check("len16_throughput", 32'(last_xfer_k - first_valid_k), 32'd15);

    // Reset in the middle of FETCH with two words buffered
    $display("[TB] mid-program reset");
    ins_ready = 1'b0;
    start_prog(4'd0, 4'd4);
    repeat (3) @(negedge clk);
    check("mrst_pre_valid", 32'(ins_valid), 32'd1);
    reset = 1'b0;
    #1;
    check("mrst_valid", 32'(ins_valid), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_rd_en", 32'(mem_rd_en), 32'd0);
    check("mrst_ins", 32'(ins), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    ins_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("mrst_stale%0d", k), 32'(ins_valid), 32'd0);
    end
    start_prog(4'd3, 4'd2);
    collect("mrst_new", 40);
    check("mrst_new_count", 32'(got_ins.size()), 32'd2);
    check_xfer("mrst_new", 0, 16'h0103, 4'd3);
    check_xfer("mrst_new", 1, 16'h0104, 4'd4);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: ADDR_W, default 4, RAM word address width (16-word program store).
REQ-002 Parameter: DATA_W, default 16, instruction width.
REQ-003 Parameter: DEPTH, default 2, instruction buffer entries.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse; begins fetching a program, honoured only in IDLE.
REQ-007 start_addr  input  ADDR_W  address of first instruction, sampled with start.
REQ-008 prog_len  input  ADDR_W  instruction count to fetch, sampled with start; 0 means 16.
REQ-009 mem_addr  output  ADDR_W  RAM read address.
REQ-010 mem_rd_en  output  1  RAM read strobe; one word requested per asserted cycle.
REQ-011 mem_rdata  input  DATA_W  RAM read data, valid exactly one cycle after mem_rd_en.
REQ-012 ins  output  DATA_W  instruction presented to the downstream controller.
REQ-013 ins_pc  output  ADDR_W  address that ins was fetched from.
REQ-014 ins_valid  output  1  ins/ins_pc hold a valid instruction.
REQ-015 ins_ready  input  1  downstream accepts; transfer occurs when ins_valid and ins_ready are both high.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse when the program is fully delivered.

Function
REQ-018 FSM states: IDLE, FETCH, DRAIN, DONE.
REQ-019 IDLE->FETCH on start; load pc=start_addr, remaining=prog_len (0 -> 16).
REQ-020 In FETCH a read issues (mem_rd_en=1, mem_addr=pc) only when buffer_count + inflight < DEPTH and remaining > 0; pc increments and remaining decrements per issue.
REQ-021 pc wraps modulo 2^ADDR_W (15 -> 0); no error.
REQ-022 Returned word is written to buffer the cycle after issue, tagged with its address.
REQ-023 FETCH->DRAIN when remaining reaches 0, or when a buffered word has ins[12:9] == HALT (4'b1111).
REQ-024 On HALT capture, a read in flight is discarded (not buffered); HALT itself is delivered.
REQ-025 DRAIN->DONE when buffer empty and no read in flight; DONE->IDLE next cycle with done=1 for that cycle only.
REQ-026 Buffer is FIFO order; ins/ins_pc driven from head; ins_valid = buffer not empty.
REQ-027 ins, ins_pc stable while ins_valid=1 and ins_ready=0.
REQ-028 Simultaneous write and pop on full buffer is legal; count unchanged.
REQ-029 Throughput: one instruction per cycle sustained when ins_ready held high.
REQ-030 start outside IDLE ignored; start_addr/prog_len changes after sampling ignored.
REQ-031 Latency: start in cycle 0 -> mem_rd_en cycle 1 -> ins_valid cycle 3.

Reset
REQ-032 reset low asynchronously forces IDLE, buffer empty, inflight=0, pc=0, remaining=0.
REQ-033 During reset: mem_addr=0, mem_rd_en=0, ins=0, ins_pc=0, ins_valid=0, busy=0, done=0.
REQ-034 Reset mid-program abandons it; returning data after reset release is dropped.

Structure
REQ-035 Package instr_fetch_pkg holds ADDR_W/DATA_W defaults, HALT opcode 4'b1111, opcode field position [12:9], and the state enumeration.
REQ-036 Buffer implemented as sub-module fetch_fifo (DEPTH x (DATA_W+ADDR_W), push/pop/full/empty/count).

Verification
REQ-037 start_addr=0, prog_len=4, ins_ready=1, RAM words 16'h0011,16'h0022,16'h1048,16'h0123 -> four transfers in order, ins_pc 0..3, done one cycle after last transfer.
REQ-038 start_addr=14, prog_len=3 -> mem_addr sequence 14,15,0; ins_pc 14,15,0.
REQ-039 prog_len=6, word at addr 2 = 16'h1E00 (HALT) -> exactly 3 transfers (addr 0,1,2), word at addr 3 never presented, done asserted.
REQ-040 ins_ready=0 for 5 cycles after start -> at most 2 reads issued, ins held at addr-0 word; release ins_ready -> remaining words in order, none lost or duplicated.
REQ-041 prog_len=0 -> 16 transfers, addresses start_addr..start_addr+15 mod 16.
REQ-042 Assert reset low mid-FETCH with 2 buffered words -> immediately ins_valid=0, busy=0; after release, no stale instruction appears; new start works normally.
